drs_event_reader: RTL and testbench

- Consumer end of the DRS readout FIFO interface: drains event words from the DRS event FIFO via a read-enable/read-data handshake, parses event framing and emits ADC samples on a valid/ready stream tagged with channel and position.
- Extracts per-event metadata (timestamp, readout mask, sample count) and flags framing errors.
- Sits between the drs readout FIFO and the downstream packetizer/transport in the same clock domain.

---
 rtl/drs_event_reader.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_drs_event_reader.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drs_event_reader.sv
// ----------------------------------------------------------------------------
// drs_event_reader
// Consumer end of the DRS readout FIFO. Pops event words with a one-cycle
// read latency and parses the framing:
//   HEADER, MASK, TS[47:32], TS[31:16], TS[15:0], COUNT, samples..., TRAILER
// ADC samples go to a 2-entry output buffer that drives a valid/ready stream
// tagged with channel and last-of-channel/last-of-event flags.
// Optional build macro: DRS_READER_COUNTERS_EN adds saturating event/error
// counters. Without it, event_count and error_count are tied to zero.
// ----------------------------------------------------------------------------
module drs_event_reader #(
    parameter int          READ_WIDTH   = 16,
    parameter int          NCHAN        = 9,
    parameter int          MAX_SAMPLES  = 1024,
    parameter logic [15:0] HEADER_WORD  = 16'hAAAA,
    parameter logic [15:0] TRAILER_WORD = 16'h5555,
    parameter int          TIMEOUT      = 255
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [READ_WIDTH-1:0] rd_data,
    input  logic                  rd_empty,
    output logic                  rd_enable,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [13:0]           out_data,
    output logic [3:0]            out_chan,
    output logic                  out_last_chan,
    output logic                  out_last_event,
    output logic                  evt_start,
    output logic [47:0]           evt_timestamp,
    output logic [NCHAN-1:0]      evt_mask,
    output logic [10:0]           evt_samples,
    output logic                  err_pulse,
    output logic [1:0]            err_code,
    output logic [15:0]           event_count,
    output logic [15:0]           error_count
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_MASK  = 3'd1,
        ST_TS2   = 3'd2,
        ST_TS1   = 3'd3,
        ST_TS0   = 3'd4,
        ST_CNT   = 3'd5,
        ST_DATA  = 3'd6,
        ST_TRAIL = 3'd7
    } state_e;

    typedef struct packed {
        logic [13:0] data;
        logic [3:0]  chan;
        logic        last_chan;
        logic        last_event;
    } entry_t;

    // Lowest set mask bit at or above 'from'; result is {found, index}.
    function automatic logic [4:0] find_chan(input logic [NCHAN-1:0] mask,
                                             input logic [4:0] from);
        logic [4:0] res;
        res = 5'd0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

    state_e           state_q, state_d;
    logic [NCHAN-1:0] mask_q, mask_d;
    logic [47:0]      ts_q, ts_d;
    logic [10:0]      samples_q, samples_d;
    logic [3:0]       chan_q, chan_d;
    logic [10:0]      idx_q, idx_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             evt_start_q, evt_start_d;
    logic             err_pulse_q, err_pulse_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             rd_inflight_q;

    entry_t           buf_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       occ_q, occ_d;
    logic             push_s, pop_s;
    entry_t           push_entry_s, head_s;

    logic [15:0]      word_s;
    logic [4:0]       first_chan_s, next_chan_s;
    logic             last_chan_s;

    assign word_s       = rd_data[15:0];
    assign first_chan_s = find_chan(mask_q, 5'd0);
    assign next_chan_s  = find_chan(mask_q, {1'b0, chan_q} + 5'd1);
    assign last_chan_s  = (idx_q == (samples_q - 11'd1));

    // Read only while the words already owed to the buffer leave room for one more;
    // header/trailer words in flight are counted conservatively as samples.
    assign pop_s     = (occ_q != 2'd0) & out_ready;
    assign rd_enable = ~rd_empty &
                       (({1'b0, occ_q} + {2'b00, rd_inflight_q} - {2'b00, pop_s}) < 3'd2);

    // Word parser: next state, metadata capture, sample push and stall timeout
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        ts_d         = ts_q;
        samples_d    = samples_q;
        chan_d       = chan_q;
        idx_d        = idx_q;
        to_cnt_d     = to_cnt_q;
        evt_start_d  = 1'b0;
        err_pulse_d  = 1'b0;
        err_code_d   = err_code_q;
        push_s       = 1'b0;
        push_entry_s = '0;
        if (rd_inflight_q) begin
            to_cnt_d = '0;
            case (state_q)
                ST_HUNT: begin
                    if (word_s == HEADER_WORD) begin
                        state_d = ST_MASK;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_MASK: begin
                    mask_d  = word_s[NCHAN-1:0];
                    state_d = ST_TS2;
                end
                ST_TS2: begin
                    ts_d[47:32] = word_s;
                    state_d     = ST_TS1;
                end
                ST_TS1: begin
                    ts_d[31:16] = word_s;
                    state_d     = ST_TS0;
                end
                ST_TS0: begin
                    ts_d[15:0] = word_s;
                    state_d    = ST_CNT;
                end
                ST_CNT: begin
                    if ((word_s == 16'd0) || (word_s > 16'(MAX_SAMPLES))) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = 2'd1;
                        state_d     = ST_HUNT;
                    end else begin
                        samples_d   = word_s[10:0];
                        evt_start_d = 1'b1;
                        idx_d       = 11'd0;
                        if (mask_q == {NCHAN{1'b0}}) begin
                            state_d = ST_TRAIL;
                        end else begin
                            chan_d  = first_chan_s[3:0];
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // A header pattern here is ordinary sample data.
                    push_s                  = 1'b1;
                    push_entry_s.data       = word_s[13:0];
                    push_entry_s.chan       = chan_q;
                    push_entry_s.last_chan  = last_chan_s;
                    push_entry_s.last_event = last_chan_s & ~next_chan_s[4];
                    if (last_chan_s) begin
                        idx_d = 11'd0;
                        if (next_chan_s[4]) begin
                            chan_d  = next_chan_s[3:0];
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_TRAIL;
                        end
                    end else begin
                        idx_d = idx_q + 11'd1;
                    end
                end
                ST_TRAIL: begin
                    state_d = ST_HUNT;
                    if (word_s == TRAILER_WORD) begin
                        err_pulse_d = 1'b0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_code_d  = 2'd2;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end else if ((state_q != ST_HUNT) && rd_empty) begin
            if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                err_pulse_d = 1'b1;
                err_code_d  = 2'd3;
                state_d     = ST_HUNT;
                to_cnt_d    = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // Parser state, metadata and strobe registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_HUNT;
            mask_q        <= '0;
            ts_q          <= '0;
            samples_q     <= '0;
            chan_q        <= '0;
            idx_q         <= '0;
            to_cnt_q      <= '0;
            evt_start_q   <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_code_q    <= 2'd0;
            rd_inflight_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            ts_q          <= ts_d;
            samples_q     <= samples_d;
            chan_q        <= chan_d;
            idx_q         <= idx_d;
            to_cnt_q      <= to_cnt_d;
            evt_start_q   <= evt_start_d;
            err_pulse_q   <= err_pulse_d;
            err_code_q    <= err_code_d;
            rd_inflight_q <= rd_enable;
        end
    end

    // Output buffer occupancy update
    always_comb begin
        occ_d = occ_q;
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Output buffer storage and pointers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_s) begin
                buf_q[wr_ptr_q] <= push_entry_s;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    assign head_s         = buf_q[rd_ptr_q];
    assign out_valid      = (occ_q != 2'd0);
    assign out_data       = head_s.data;
    assign out_chan       = head_s.chan;
    assign out_last_chan  = head_s.last_chan;
    assign out_last_event = head_s.last_event;
    assign evt_start      = evt_start_q;
    assign evt_timestamp  = ts_q;
    assign evt_mask       = mask_q;
    assign evt_samples    = samples_q;
    assign err_pulse      = err_pulse_q;
    assign err_code       = err_code_q;

`ifdef DRS_READER_COUNTERS_EN
    logic [15:0] event_count_q;
    logic [15:0] error_count_q;
    logic        good_evt_s;

    assign good_evt_s = rd_inflight_q & (state_q == ST_TRAIL) & (word_s == TRAILER_WORD);

    // Saturating counts of accepted trailers and error strobes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            event_count_q <= 16'd0;
            error_count_q <= 16'd0;
        end else begin
            if (good_evt_s && (event_count_q != 16'hFFFF)) begin
                event_count_q <= event_count_q + 16'd1;
            end
            if (err_pulse_q && (error_count_q != 16'hFFFF)) begin
                error_count_q <= error_count_q + 16'd1;
            end
        end
    end

    assign event_count = event_count_q;
    assign error_count = error_count_q;
`else
    assign event_count = 16'd0;
    assign error_count = 16'd0;
`endif

endmodule

// File: tb/tb_drs_event_reader.sv
// ----------------------------------------------------------------------------
// tb_drs_event_reader
// Table of directed events, a randomized event stream with back-pressure and
// FIFO stalls, and hand-written timeout / mid-event reset sequences. The
// expected sample, metadata and error streams are built from the event
// description while the FIFO word list is generated.
// ----------------------------------------------------------------------------
module tb_drs_event_reader;

    typedef logic [67:0] rec_t;

    typedef struct {
        logic [8:0]  mask;
        logic [15:0] cnt;
        logic [47:0] ts;
        logic [15:0] trailer;
        int          ready_mode;
        int          garbage;
        int          exp_n;
        logic [1:0]  exp_code;
    } vec_t;

`ifdef DRS_READER_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] rd_data;
    logic        rd_empty;
    logic        rd_enable;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_data;
    logic [3:0]  out_chan;
    logic        out_last_chan;
    logic        out_last_event;
    logic        evt_start;
    logic [47:0] evt_timestamp;
    logic [8:0]  evt_mask;
    logic [10:0] evt_samples;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic [15:0] event_count;
    logic [15:0] error_count;

    always #5 clock = ~clock;

    drs_event_reader dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .rd_data       (rd_data),
        .rd_empty      (rd_empty),
        .rd_enable     (rd_enable),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_chan      (out_chan),
        .out_last_chan (out_last_chan),
        .out_last_event(out_last_event),
        .evt_start     (evt_start),
        .evt_timestamp (evt_timestamp),
        .evt_mask      (evt_mask),
        .evt_samples   (evt_samples),
        .err_pulse     (err_pulse),
        .err_code      (err_code),
        .event_count   (event_count),
        .error_count   (error_count)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] fifo[$];
    rec_t        exp_s[$], got_s[$], exp_m[$], got_m[$], exp_e[$], got_e[$];
    int          exp_good = 0;
    int          exp_bad = 0;
    int          ready_mode = 0;
    bit          stall_en = 1'b0;
    bit          force_empty = 1'b0;
    bit          inflight_tb = 1'b0;
    bit          prev_stall = 1'b0;
    logic [19:0] prev_word = '0;
    bit          tog = 1'b0;
    int          empty_run = 0;
    int          to_seen_at = 0;
    vec_t        tbl[9];

    // One clock cycle: observe at the negedge, then model the FIFO after the posedge.
    task automatic step();
        logic ren;
        logic hold;
        ren = rd_enable;
        if (prev_stall) begin
            n_checks++;
            if (!out_valid || ({out_data, out_chan, out_last_chan, out_last_event} != prev_word)) begin
                n_errors++;
                $display("FAIL hold_stable: got valid=%0d word=%h required valid=1 word=%h",
                         out_valid, {out_data, out_chan, out_last_chan, out_last_event}, prev_word);
            end
        end
        prev_stall = out_valid & ~out_ready;
        prev_word  = {out_data, out_chan, out_last_chan, out_last_event};
        if (out_valid && out_ready) got_s.push_back(rec_t'({out_data, out_chan, out_last_chan, out_last_event}));
        if (evt_start) got_m.push_back({evt_timestamp, evt_mask, evt_samples});
        if (err_pulse) got_e.push_back(rec_t'(err_code));
        if (rd_empty && !inflight_tb) empty_run++;
        else empty_run = 0;
        if (err_pulse && (err_code == 2'd3) && (to_seen_at == 0)) to_seen_at = empty_run;
        @(posedge clock);
        #1;
        if (ren) begin
            n_checks++;
            if (fifo.size() == 0) begin
                n_errors++;
                $display("FAIL pop_empty: got rd_enable=1 with empty FIFO required rd_enable=0");
                rd_data = 16'($urandom);
            end else begin
                rd_data = fifo.pop_front();
            end
        end else begin
            rd_data = 16'($urandom);
        end
        inflight_tb = ren;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin tog = ~tog; out_ready = tog; end
            2: out_ready = 1'($urandom_range(0, 1));
            3: out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
        hold = stall_en && ($urandom_range(0, 7) == 0);
        rd_empty = force_empty || hold || (fifo.size() == 0);
        @(negedge clock);
    endtask

    // Push one event's words into the FIFO and extend the expected streams.
    task automatic gen_event(input logic [8:0] mask, input logic [15:0] cnt,
                             input logic [47:0] ts, input logic [15:0] trailer);
        logic [15:0] w;
        int hi;
        fifo.push_back(16'hAAAA);
        w = 16'($urandom);
        w[8:0] = mask;
        fifo.push_back(w);
        fifo.push_back(ts[47:32]);
        fifo.push_back(ts[31:16]);
        fifo.push_back(ts[15:0]);
        fifo.push_back(cnt);
        if ((cnt == 16'd0) || (cnt > 16'd1024)) begin
            exp_e.push_back(rec_t'(2'd1));
            exp_bad++;
            return;
        end
        exp_m.push_back({ts, mask, cnt[10:0]});
        hi = -1;
        for (int c = 0; c < 9; c++) if (mask[c]) hi = c;
        for (int c = 0; c < 9; c++) begin
            if (mask[c]) begin
                for (int j = 0; j < int'(cnt); j++) begin
                    w = 16'($urandom);
                    fifo.push_back(w);
                    exp_s.push_back(rec_t'({w[13:0], 4'(c), (j == int'(cnt) - 1),
                                            ((j == int'(cnt) - 1) && (c == hi))}));
                end
            end
        end
        fifo.push_back(trailer);
        if (trailer == 16'h5555) begin
            exp_good++;
        end else begin
            exp_e.push_back(rec_t'(2'd2));
            exp_bad++;
        end
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int b;
        b = budget;
        while (((fifo.size() != 0) || (got_s.size() < exp_s.size())) && (b > 0)) begin
            step();
            b--;
        end
        repeat (4) step();
        n_checks++;
        if (b == 0) begin
            n_errors++;
            $display("FAIL %s drain: got %0d samples, %0d FIFO words left required all consumed within %0d cycles",
                     name, got_s.size(), fifo.size(), budget);
        end
    endtask

    task automatic cmp_q(input string name, input rec_t got[$], input rec_t exp[$]);
        int d;
        int n;
        rec_t ga;
        rec_t ea;
        d = -1;
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            if ((d < 0) && (got[i] !== exp[i])) d = i;
        end
        if ((d < 0) && (got.size() != exp.size())) d = n;
        n_checks++;
        if (d >= 0) begin
            ga = (d < got.size()) ? got[d] : '0;
            ea = (d < exp.size()) ? exp[d] : '0;
            n_errors++;
            $display("FAIL %s: index %0d got %h (%0d entries) required %h (%0d entries)",
                     name, d, ga, got.size(), ea, exp.size());
        end
    endtask

    task automatic check_counts(input string name);
        logic [15:0] ee;
        logic [15:0] er;
        ee = CNT_EN ? 16'(exp_good) : 16'd0;
        er = CNT_EN ? 16'(exp_bad) : 16'd0;
        n_checks++;
        if ((event_count !== ee) || (error_count !== er)) begin
            n_errors++;
            $display("FAIL %s counters: got ev=%0d err=%0d required ev=%0d err=%0d",
                     name, event_count, error_count, ee, er);
        end
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if ({rd_enable, out_valid, out_data, out_chan, out_last_chan, out_last_event, evt_start,
             evt_timestamp, evt_mask, evt_samples, err_pulse, err_code, event_count, error_count} !== '0) begin
            n_errors++;
            $display("FAIL %s outputs: got valid=%0d data=%h ts=%h mask=%h smp=%0d code=%0d ren=%0d required all 0",
                     name, out_valid, out_data, evt_timestamp, evt_mask, evt_samples, err_code, rd_enable);
        end
    endtask

    task automatic compare_all(input string name);
        cmp_q({name, " samples"}, got_s, exp_s);
        cmp_q({name, " metadata"}, got_m, exp_m);
        cmp_q({name, " errors"}, got_e, exp_e);
        check_counts(name);
        got_s.delete(); exp_s.delete();
        got_m.delete(); exp_m.delete();
        got_e.delete(); exp_e.delete();
    endtask

    initial begin
        logic [1:0]  code;
        logic [15:0] w;
        logic [15:0] cnt;
        logic [15:0] trl;
        logic [47:0] ts;
        int          r;

        reset_n   = 1'b0;
        rd_empty  = 1'b1;
        rd_data   = 16'd0;
        out_ready = 1'b0;

        tbl[0] = '{mask: 9'h005, cnt: 16'd4,    ts: 48'h0123_4567_89AB, trailer: 16'h5555, ready_mode: 0, garbage: 0, exp_n: 8,    exp_code: 2'd0};
        tbl[1] = '{mask: 9'h005, cnt: 16'd4,    ts: 48'h0123_4567_89AB, trailer: 16'h5555, ready_mode: 1, garbage: 0, exp_n: 8,    exp_code: 2'd0};
        tbl[2] = '{mask: 9'h0A1, cnt: 16'd3,    ts: 48'hFEDC_BA98_7654, trailer: 16'h5555, ready_mode: 2, garbage: 1, exp_n: 9,    exp_code: 2'd0};
        tbl[3] = '{mask: 9'h003, cnt: 16'd0,    ts: 48'h0000_0000_0001, trailer: 16'h5555, ready_mode: 0, garbage: 0, exp_n: 0,    exp_code: 2'd1};
        tbl[4] = '{mask: 9'h003, cnt: 16'd1025, ts: 48'h0000_0000_0002, trailer: 16'h5555, ready_mode: 0, garbage: 0, exp_n: 0,    exp_code: 2'd1};
        tbl[5] = '{mask: 9'h000, cnt: 16'd5,    ts: 48'h1111_2222_3333, trailer: 16'h5555, ready_mode: 0, garbage: 0, exp_n: 0,    exp_code: 2'd1};
        tbl[6] = '{mask: 9'h006, cnt: 16'd3,    ts: 48'h4444_5555_6666, trailer: 16'h5556, ready_mode: 1, garbage: 0, exp_n: 6,    exp_code: 2'd2};
        tbl[7] = '{mask: 9'h100, cnt: 16'd1024, ts: 48'h7777_8888_9999, trailer: 16'h5555, ready_mode: 0, garbage: 0, exp_n: 1024, exp_code: 2'd2};
        tbl[8] = '{mask: 9'h1FF, cnt: 16'd1,    ts: 48'hAAAA_BBBB_CCCC, trailer: 16'h5555, ready_mode: 2, garbage: 0, exp_n: 9,    exp_code: 2'd2};

        repeat (3) @(negedge clock);
        check_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Directed events; exp_code is the held err_code after each one.
        code = 2'd0;
        for (int v = 0; v < 9; v++) begin
            ready_mode = tbl[v].ready_mode;
            if (tbl[v].garbage != 0) begin
                fifo.push_back(16'h1234);
                fifo.push_back(16'h0000);
            end
            gen_event(tbl[v].mask, tbl[v].cnt, tbl[v].ts, tbl[v].trailer);
            run_until_idle($sformatf("vec%0d", v), 5000);
            n_checks++;
            if (got_s.size() != tbl[v].exp_n) begin
                n_errors++;
                $display("FAIL vec%0d sample_count: got %0d required %0d", v, got_s.size(), tbl[v].exp_n);
            end
            n_checks++;
            if (err_code !== tbl[v].exp_code) begin
                n_errors++;
                $display("FAIL vec%0d err_code: got %0d required %0d", v, err_code, tbl[v].exp_code);
            end
            compare_all($sformatf("vec%0d", v));
        end

        // Randomized stream with back-pressure, FIFO stalls and framing errors.
        ready_mode = 2;
        stall_en   = 1'b1;
        for (int e = 0; e < 40; e++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                w = 16'($urandom);
                if (w == 16'hAAAA) w = 16'h1234;
                fifo.push_back(w);
            end
            r   = int'($urandom_range(0, 9));
            cnt = 16'($urandom_range(1, 6));
            trl = 16'h5555;
            if (r == 0) cnt = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1025, 65535));
            if (r == 1) trl = 16'($urandom_range(0, 16'h5554));
            ts = {16'($urandom), 32'($urandom)};
            gen_event(9'($urandom), cnt, ts, trl);
        end
        run_until_idle("random", 20000);
        compare_all("random");
        stall_en = 1'b0;

        // FIFO runs dry after the second sample of a 4-sample event.
        ready_mode = 0;
        to_seen_at = 0;
        fifo.push_back(16'hAAAA);
        fifo.push_back(16'h0001);
        fifo.push_back(16'h0BAD);
        fifo.push_back(16'hCAFE);
        fifo.push_back(16'hF00D);
        fifo.push_back(16'd4);
        fifo.push_back(16'hC123);
        fifo.push_back(16'h3456);
        exp_m.push_back({48'h0BAD_CAFE_F00D, 9'h001, 11'd4});
        exp_s.push_back(rec_t'({14'h0123, 4'd0, 1'b0, 1'b0}));
        exp_s.push_back(rec_t'({14'h3456, 4'd0, 1'b0, 1'b0}));
        exp_e.push_back(rec_t'(2'd3));
        exp_bad++;
        repeat (300) step();
        n_checks++;
        if ((to_seen_at < 255) || (to_seen_at > 256)) begin
            n_errors++;
            $display("FAIL timeout_cycle: got err at empty cycle %0d required 255..256", to_seen_at);
        end
        n_checks++;
        if (err_code !== 2'd3) begin
            n_errors++;
            $display("FAIL timeout_code: got %0d required 3", err_code);
        end
        compare_all("timeout");

        // Reset in the middle of a stalled event.
        ready_mode = 3;
        gen_event(9'h003, 16'd4, 48'h1357_9BDF_2468, 16'h5555);
        repeat (15) step();
        force_empty = 1'b1;
        rd_empty    = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("midreset");
        @(negedge clock);
        @(negedge clock);
        reset_n     = 1'b1;
        fifo.delete();
        got_s.delete(); exp_s.delete();
        got_m.delete(); exp_m.delete();
        got_e.delete(); exp_e.delete();
        exp_good    = 0;
        exp_bad     = 0;
        inflight_tb = 1'b0;
        prev_stall  = 1'b0;
        force_empty = 1'b0;
        ready_mode  = 0;
        gen_event(9'h012, 16'd2, 48'h0F0F_F0F0_A5A5, 16'h5555);
        run_until_idle("postreset", 2000);
        compare_all("postreset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
